// File: rtl/axi_rd_fifo_sched_pkg.sv
// axi_rd_fifo_sched_pkg: shared AXI codes, field widths and scheduler state encoding
package axi_rd_fifo_sched_pkg;
    localparam int ID_W = 4;
    localparam int LEN_W = 8;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    typedef enum logic [7:0] {
        ST_IDLE      = 8'h01,
        ST_BURST     = 8'h02,
        ST_ERR_BURST = 8'h04
    } state_t;
endpackage

// File: rtl/axi_rd_fifo_sched_cmd_fifo.sv
// axi_cmd_fifo: synchronous FIFO (power-of-2 depth) holding accepted AR commands
module axi_cmd_fifo
    import axi_rd_fifo_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;

    assign full = count == (AW + 1)'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rptr];

    // pointers and occupancy; pointers wrap naturally because depth is a power of 2
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= do_push ? wptr + 1'b1 : wptr;
            rptr <= do_pop ? rptr + 1'b1 : rptr;
            count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    // storage needs no reset; only entries behind count are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/axi_rd_fifo_sched.sv
// axi_rd_fifo_sched: shares one AXI4 read port among NUM_FIFO FWFT output FIFOs, in AR order
module axi_rd_fifo_sched
    import axi_rd_fifo_sched_pkg::*;
#(
    parameter int NUM_FIFO   = 4,
    parameter int SEL_W      = 2,
    parameter int SEL_LSB    = 12,
    parameter int CMDQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [3:0]          axs_s0_arid,
    input  logic [31:0]         axs_s0_araddr,
    input  logic [7:0]          axs_s0_arlen,
    input  logic [2:0]          axs_s0_arsize,
    input  logic [1:0]          axs_s0_arburst,
    input  logic                axs_s0_arvalid,
    output logic                axs_s0_arready,
    output logic [3:0]          axs_s0_rid,
    output logic [1:0]          axs_s0_rresp,
    output logic                axs_s0_rlast,
    output logic                axs_s0_rvalid,
    input  logic                axs_s0_rready,
    input  logic [NUM_FIFO-1:0] out_fifo_empty,
    output logic                out_fifo_pop,
    output logic [SEL_W-1:0]    out_fifo_pop_sel
);
    localparam int ENT_W = ID_W + SEL_W + LEN_W + 1 + 3 + 2;
    localparam int SEL_N = 1 << SEL_W;

    state_t state, state_nxt;
    logic [ID_W-1:0] rid_q, h_id;
    logic [SEL_W-1:0] sel_q, ar_sel, h_sel;
    logic [LEN_W-1:0] beat_cnt, h_len;
    logic [1:0] resp_q, h_burst;
    logic [2:0] h_size;
    logic ar_err, h_err, q_full, q_empty, q_pop, beat_hs, last_hs;
    logic [ENT_W-1:0] q_head;
    logic [$clog2(CMDQ_DEPTH):0] q_count;
    logic [SEL_N-1:0] empty_ext;
    logic unused_ok;

    assign ar_sel = axs_s0_araddr[SEL_LSB +: SEL_W];
    assign ar_err = 32'(ar_sel) >= 32'(NUM_FIFO);
    assign axs_s0_arready = !q_full;
    assign {h_id, h_sel, h_len, h_err, h_size, h_burst} = q_head;
    // error bursts never consult the empty flags, so out-of-range selects may read padding
    assign empty_ext = SEL_N'(out_fifo_empty);
    assign axs_s0_rid = rid_q;
    assign axs_s0_rresp = resp_q;
    assign out_fifo_pop_sel = sel_q;
    assign unused_ok = ^{axs_s0_araddr, h_size, h_burst, q_count};

    axi_cmd_fifo #(.WIDTH(ENT_W), .DEPTH(CMDQ_DEPTH)) u_cmdq (
        .clk   (clk),
        .reset_n(reset_n),
        .push  (axs_s0_arvalid && !q_full),
        .din   ({axs_s0_arid, ar_sel, axs_s0_arlen, ar_err, axs_s0_arsize, axs_s0_arburst}),
        .pop   (q_pop),
        .dout  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else state <= state_nxt;
    end

    // next state: load from queue when idle or on the final beat, else fall back to idle after it
    always_comb begin
        state_nxt = q_pop ? (h_err ? ST_ERR_BURST : ST_BURST) : (last_hs ? ST_IDLE : state);
    end

    // R channel and FIFO pop decode; rvalid follows FIFO emptiness for real bursts
    always_comb begin
        axs_s0_rvalid = (state == ST_ERR_BURST) || (state == ST_BURST && !empty_ext[sel_q]);
        beat_hs = axs_s0_rvalid && axs_s0_rready;
        last_hs = beat_hs && beat_cnt == '0;
        q_pop = !q_empty && (state == ST_IDLE || last_hs);
        axs_s0_rlast = axs_s0_rvalid && beat_cnt == '0;
        out_fifo_pop = beat_hs && state == ST_BURST;
    end

    // burst context: loaded on queue pop, beat counter steps down per handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rid_q <= '0;
            sel_q <= '0;
            resp_q <= '0;
            beat_cnt <= '0;
        end else if (q_pop) begin
            rid_q <= h_id;
            sel_q <= h_sel;
            beat_cnt <= h_len;
            resp_q <= h_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end else if (beat_hs && beat_cnt != '0) begin
            beat_cnt <= beat_cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_rd_fifo_sched.sv
// tb_axi_rd_fifo_sched: scoreboard bench; expected beats queued per AR, checked per R handshake
module tb_axi_rd_fifo_sched;
    localparam int NF = 3;
    localparam int SW = 2;
    localparam int SL = 12;
    localparam int QD = 4;

    logic clk = 0;
    logic reset_n = 0;
    logic [3:0] arid = 0;
    logic [31:0] araddr = 0;
    logic [7:0] arlen = 0;
    logic [2:0] arsize = 0;
    logic [1:0] arburst = 0;
    logic arvalid = 0, arready;
    logic [3:0] rid;
    logic [1:0] rresp;
    logic rlast, rvalid;
    logic rready = 0;
    logic [NF-1:0] fifo_empty = '0;
    logic pop;
    logic [SW-1:0] pop_sel;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic last;
        logic [1:0] sel;
        logic err;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0, failures = 0;
    int pop_cnt = 0, hs_cnt = 0, ar_cnt = 0;
    bit stim_done = 0;

    always #5 clk = ~clk;

    axi_rd_fifo_sched #(.NUM_FIFO(NF), .SEL_W(SW), .SEL_LSB(SL), .CMDQ_DEPTH(QD)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .axs_s0_arid     (arid),
        .axs_s0_araddr   (araddr),
        .axs_s0_arlen    (arlen),
        .axs_s0_arsize   (arsize),
        .axs_s0_arburst  (arburst),
        .axs_s0_arvalid  (arvalid),
        .axs_s0_arready  (arready),
        .axs_s0_rid      (rid),
        .axs_s0_rresp    (rresp),
        .axs_s0_rlast    (rlast),
        .axs_s0_rvalid   (rvalid),
        .axs_s0_rready   (rready),
        .out_fifo_empty  (fifo_empty),
        .out_fifo_pop    (pop),
        .out_fifo_pop_sel(pop_sel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ar(input logic [3:0] id, input logic [1:0] sel, input logic [7:0] len);
        logic [31:0] a;
        int t = 0;
        a = $urandom;
        a[SL +: SW] = sel;
        arid = id;
        araddr = a;
        arlen = len;
        arsize = 3'($urandom);
        arburst = 2'($urandom);
        arvalid = 1;
        while (!arready && t < 2000) begin
            cyc(1);
            t++;
        end
        if (!arready) begin
            checks++;
            failures++;
            $display("FAIL ar_timeout id=%0h arready stayed low", id);
            arvalid = 0;
        end else begin
            cyc(1);
            arvalid = 0;
        end
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() > 0 && t < 5000) begin
            cyc(1);
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // monitor: score R beats against the model, then record newly accepted ARs as expected beats
    always @(negedge clk) begin
        beat_t e;
        if (pop) pop_cnt++;
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rvalid rid=%0h rresp=%0h", rid, rresp);
            end else begin
                e = exp_q[0];
                check("rid", rid, e.id);
                check("rresp", rresp, e.resp);
                check("rlast", rlast, e.last);
                check("pop_on_beat", pop, rready && !e.err);
                if (!e.err) begin
                    check("pop_sel", pop_sel, e.sel);
                    check("rvalid_while_empty", fifo_empty[e.sel], 0);
                end
                if (rready) begin
                    void'(exp_q.pop_front());
                    hs_cnt++;
                end
            end
        end else begin
            check("pop_without_rvalid", pop, 0);
            check("rlast_without_rvalid", rlast, 0);
        end
        if (arvalid && arready) begin
            logic [1:0] s;
            logic err;
            s = araddr[SL +: SW];
            err = 32'(s) >= NF;
            ar_cnt++;
            for (int i = 0; i <= int'(arlen); i++)
                exp_q.push_back(beat_t'{arid, err ? 2'b10 : 2'b00, i == int'(arlen), s, err});
        end
    end

    initial begin
        int p0, h0, a0, t;
        #1;
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_pop", pop, 0);
        check("rst_rid", rid, 0);
        check("rst_rresp", rresp, 0);
        check("rst_pop_sel", pop_sel, 0);
        cyc(2);
        reset_n = 1;
        cyc(1);
        check("arready_after_reset", arready, 1);

        // single burst with exact AR->R latency
        rready = 1;
        p0 = pop_cnt;
        ar(4'd5, 2'd1, 8'd3);
        check("latency_n1_rvalid", rvalid, 0);
        cyc(1);
        check("latency_n2_rvalid", rvalid, 1);
        drain("single_drain");
        check("single_pops", pop_cnt - p0, 4);

        // back-to-back bursts must stream without a bubble
        rready = 0;
        ar(4'd1, 2'd0, 8'd0);
        ar(4'd2, 2'd2, 8'd1);
        cyc(3);
        h0 = hs_cnt;
        rready = 1;
        cyc(3);
        check("b2b_contiguous_beats", hs_cnt - h0, 3);
        drain("b2b_drain");

        // backpressure and empty stalls on FIFO 2
        p0 = pop_cnt;
        ar(4'd3, 2'd2, 8'd7);
        t = 0;
        while (exp_q.size() > 0 && t < 2000) begin
            rready = $urandom_range(0, 1) == 1;
            fifo_empty[2] = $urandom_range(0, 2) == 0;
            cyc(1);
            t++;
        end
        fifo_empty = '0;
        rready = 1;
        drain("stall_drain");
        check("stall_pops", pop_cnt - p0, 8);

        // queue full: one burst in flight plus QD queued
        rready = 0;
        a0 = ar_cnt;
        arvalid = 1;
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a;
            a = $urandom;
            a[SL +: SW] = 2'($urandom_range(0, 2));
            araddr = a;
            arid = 4'($urandom);
            arlen = 8'($urandom_range(0, 3));
            cyc(1);
        end
        arvalid = 0;
        check("full_accepted", ar_cnt - a0, QD + 1);
        check("full_arready", arready, 0);
        rready = 1;
        t = 0;
        while (!arready && t < 50) begin
            cyc(1);
            t++;
        end
        check("full_resume_arready", arready, 1);
        drain("full_drain");

        // out-of-range select -> SLVERR beats, no pops
        p0 = pop_cnt;
        ar(4'd7, 2'd3, 8'd2);
        drain("err_drain");
        check("err_pops", pop_cnt - p0, 0);

        // longest burst
        p0 = pop_cnt;
        ar(4'd4, 2'd0, 8'd255);
        drain("long_drain");
        check("long_pops", pop_cnt - p0, 256);

        // reset mid-burst aborts and flushes
        rready = 0;
        ar(4'd9, 2'd1, 8'd7);
        ar(4'd10, 2'd2, 8'd3);
        cyc(3);
        check("pre_reset_rvalid", rvalid, 1);
        #2;
        reset_n = 0;
        exp_q.delete();
        #1;
        check("reset_rvalid_now", rvalid, 0);
        check("reset_pop_now", pop, 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        rready = 1;
        h0 = hs_cnt;
        cyc(6);
        check("post_reset_no_beats", hs_cnt - h0, 0);
        check("post_reset_arready", arready, 1);

        // randomized traffic with random backpressure and empties
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    ar(4'($urandom), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 12)));
                    cyc($urandom_range(0, 3));
                end
                stim_done = 1;
            end
            begin
                int k = 0;
                while ((!stim_done || exp_q.size() > 0) && k < 30000) begin
                    rready = $urandom_range(0, 3) != 0;
                    for (int f = 0; f < NF; f++) fifo_empty[f] = $urandom_range(0, 3) == 0;
                    cyc(1);
                    k++;
                end
            end
        join
        fifo_empty = '0;
        rready = 1;
        drain("random_drain");
        cyc(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
